thread_scheduler: RTL and testbench
===================================

Name: thread_scheduler

Overview:
- Front-end thread selector. It consumes the per-thread PCs and retire/replay strobes produced by writeback, and the exception-forcing signals exc_en and exc_thread.
- It chooses which hardware thread fetches next and presents that thread's PC to the fetch stage over a valid/ready handshake.
- Each thread has at most one instruction in flight. A thread becomes eligible again only after writeback reports its next PC.
- Round-robin fairness applies, except in exception state, where only the exception master thread may issue.

Parameters:
N_THREADS, 4, number of hardware threads (matches common n_threads)
BOOT_PC, 32'h1000, PC loaded into every thread at reset
PC_W, 32, PC width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
wb_pc  in  N_THREADS x PC_W  next PC per thread from writeback
wb_done  in  N_THREADS  per-thread pulse: wb_pc[t] is valid, thread t's in-flight instruction retired or will replay
exc_en  in  1  exception state active
exc_thread  in  $clog2(N_THREADS)  exception master thread
thread_en  in  N_THREADS  thread enable mask
if_valid  out  1  fetch request valid
if_ready  in  1  fetch stage accepts the request
if_thread  out  $clog2(N_THREADS)  thread id of the request
if_pc  out  PC_W  fetch PC
inflight  out  N_THREADS  per-thread in-flight flag
proto_err  out  1  sticky: wb_done seen for a thread that was not in flight

Behaviour:
- Per-thread state: READY or INFLIGHT, plus register next_pc[t].
- Reset (rst=0, asynchronous):
  - all threads READY; next_pc[t]=BOOT_PC; round-robin pointer rr=0
  - if_valid=0, if_thread=0, if_pc=0, inflight=0, proto_err=0
- Eligibility: thread t is eligible iff it is READY, thread_en[t]=1, and it is not already presented. When exc_en=1, thread t must also equal exc_thread.
- Selection: first eligible thread scanning rr, rr+1, ... with wrap modulo N_THREADS.
- Output register: if_valid, if_thread and if_pc are registered.
  - A thread that becomes eligible in cycle n is presented no earlier than cycle n+1.
  - When if_valid=0, or if_valid=1 and if_ready=1, load the selection for the next cycle. If nothing is eligible, if_valid goes to 0.
  - While if_valid=1 and if_ready=0, if_thread and if_pc hold stable. Changes to exc_en or thread_en do not withdraw the held request.
- Accept (if_valid and if_ready):
  - presented thread moves to INFLIGHT
  - rr becomes (if_thread+1) mod N_THREADS
  - back-to-back issue of different threads is allowed every cycle
- wb_done[t] with thread t INFLIGHT: next_pc[t] <= wb_pc[t], thread t moves to READY. Multiple threads may complete in the same cycle.
- wb_done[t] with thread t READY: ignored (next_pc unchanged), and proto_err is set. proto_err clears only on reset.
- Accept and wb_done on different threads in the same cycle: both take effect.
- thread_en[t] cleared while thread t is INFLIGHT: the thread still completes and returns to READY, but is not selected again.
- inflight[t] = (state[t]==INFLIGHT), registered.
- Width: rr and thread ids use $clog2(N_THREADS) bits. The wrap uses an explicit modulo, so N_THREADS need not be a power of two.

Optional Feature:
Macro THREAD_SCHED_PERF_EN.
- Defined:
  - adds output perf_issue_cnt, N_THREADS x 32: per-thread accepted-request counters, wrapping modulo 2^32
  - adds output perf_stall_cnt, 32 bits: counts cycles with if_valid=1 and if_ready=0
  - all counters reset to 0
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, if_ready=1, wb_done pulsed one cycle after each accept with wb_pc=if_pc+4 → issue order T0,T1,T2,T3,T0 at PCs 0x1000 ×4, then 0x1004 for T0.
- Hold if_ready=0 for 5 cycles while T1 is presented at 0x2000 → if_thread=1 and if_pc=0x2000 stable throughout; exactly one accept when ready rises; inflight[1]=1 the next cycle.
- exc_en=1, exc_thread=2, all threads READY → only T2 issued repeatedly. exc_en drops → round robin resumes from T3.
- wb_done[0]=1 while T0 is READY → next_pc[0] unchanged; proto_err=1 and it stays set.
- thread_en=4'b0101 → only T0 and T2 alternate. Clear thread_en[2] while T2 is in flight → T2 completes (inflight[2] drops) and is never reissued.
- Assert rst=0 mid-stream with T1 presented and T3 in flight → next clock: if_valid=0, inflight=0, all next_pc=0x1000, and the first issue after release is T0.

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin hardware-thread selector feeding fetch over a valid/ready handshake.
// Optional per-thread issue / stall counters are built when THREAD_SCHED_PERF_EN is defined.
module thread_scheduler #(
  parameter int          N_THREADS = 4,
  parameter logic [31:0] BOOT_PC   = 32'h1000,
  parameter int          PC_W      = 32,
  localparam int         TID_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_THREADS-1:0][PC_W-1:0]      wb_pc,
  input  logic [N_THREADS-1:0]                wb_done,
  input  logic                                exc_en,
  input  logic [TID_W-1:0]                    exc_thread,
  input  logic [N_THREADS-1:0]                thread_en,
  output logic                                if_valid,
  input  logic                                if_ready,
  output logic [TID_W-1:0]                    if_thread,
  output logic [PC_W-1:0]                     if_pc,
  output logic [N_THREADS-1:0]                inflight,
  output logic                                proto_err
`ifdef THREAD_SCHED_PERF_EN
  ,
  output logic [N_THREADS-1:0][31:0]          perf_issue_cnt,
  output logic [31:0]                         perf_stall_cnt
`endif
);

  logic [N_THREADS-1:0]            inflight_q;
  logic [N_THREADS-1:0][PC_W-1:0]  next_pc_q;
  logic [TID_W-1:0]                rr_q;
  logic [TID_W-1:0]                rr_d;
  logic                            if_valid_q;
  logic [TID_W-1:0]                if_thread_q;
  logic [PC_W-1:0]                 if_pc_q;
  logic                            proto_err_q;

  logic                            accept;
  logic                            load;
  logic [TID_W:0]                  tid_inc;
  logic [N_THREADS-1:0]            elig;
  logic                            found;
  logic [TID_W-1:0]                sel;
  int                              idx;

  // The scan starts from the pointer as updated by this cycle's accept, so a
  // thread issued now is scanned last when picking the next request.
  always_comb begin
    accept  = if_valid_q && if_ready;
    load    = !if_valid_q || if_ready;
    tid_inc = {1'b0, if_thread_q} + (TID_W+1)'(1);
    rr_d    = rr_q;
    if (accept) begin
      rr_d = (tid_inc == (TID_W+1)'(N_THREADS)) ? '0 : tid_inc[TID_W-1:0];
    end

    for (int t = 0; t < N_THREADS; t++) begin
      elig[t] = !inflight_q[t] && thread_en[t] &&
                !(if_valid_q && (if_thread_q == TID_W'(t))) &&
                (!exc_en || (exc_thread == TID_W'(t)));
    end

    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_THREADS; k++) begin
      idx = int'(rr_d) + k;
      if (idx >= N_THREADS) idx = idx - N_THREADS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = TID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q  <= '0;
      rr_q        <= '0;
      if_valid_q  <= 1'b0;
      if_thread_q <= '0;
      if_pc_q     <= '0;
      proto_err_q <= 1'b0;
      for (int t = 0; t < N_THREADS; t++) begin
        next_pc_q[t] <= PC_W'(BOOT_PC);
      end
    end else begin
      rr_q <= rr_d;
      if (load) begin
        if_valid_q <= found;
        if (found) begin
          if_thread_q <= sel;
          if_pc_q     <= next_pc_q[sel];
        end
      end
      // Completion is judged on the pre-edge state, so an accept and a
      // completion for the same thread in one cycle flag a protocol error.
      for (int t = 0; t < N_THREADS; t++) begin
        if (wb_done[t]) begin
          if (inflight_q[t]) begin
            inflight_q[t] <= 1'b0;
            next_pc_q[t]  <= wb_pc[t];
          end else begin
            proto_err_q <= 1'b1;
          end
        end
      end
      if (accept) begin
        inflight_q[if_thread_q] <= 1'b1;
      end
    end
  end

  assign if_valid  = if_valid_q;
  assign if_thread = if_thread_q;
  assign if_pc     = if_pc_q;
  assign inflight  = inflight_q;
  assign proto_err = proto_err_q;

`ifdef THREAD_SCHED_PERF_EN
  logic [N_THREADS-1:0][31:0] issue_cnt_q;
  logic [31:0]                stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        issue_cnt_q[if_thread_q] <= issue_cnt_q[if_thread_q] + 32'd1;
      end
      if (if_valid_q && !if_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: directed scenarios plus randomized traffic, all
// compared every cycle against a cycle-level behavioural model of the scheduler.
module tb_thread_scheduler;

  localparam int          N    = 4;
  localparam logic [31:0] BOOT = 32'h1000;
  localparam int          M_AUTO   = 0;
  localparam int          M_MANUAL = 1;
  localparam int          M_RAND   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0][31:0] wb_pc;
  logic [N-1:0]      wb_done;
  logic              exc_en;
  logic [1:0]        exc_thread;
  logic [N-1:0]      thread_en;
  logic              if_ready;
  logic              if_valid;
  logic [1:0]        if_thread;
  logic [31:0]       if_pc;
  logic [N-1:0]      inflight;
  logic              proto_err;
`ifdef THREAD_SCHED_PERF_EN
  logic [N-1:0][31:0] perf_issue_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  thread_scheduler #(.N_THREADS(N), .BOOT_PC(BOOT), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_done(wb_done),
    .exc_en(exc_en), .exc_thread(exc_thread), .thread_en(thread_en),
    .if_valid(if_valid), .if_ready(if_ready), .if_thread(if_thread),
    .if_pc(if_pc), .inflight(inflight), .proto_err(proto_err)
`ifdef THREAD_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_infl[N];
  logic [31:0] m_npc[N];
  logic [31:0] m_acc_pc[N];
  int          m_rr;
  bit          m_valid;
  int          m_tid;
  logic [31:0] m_pc;
  bit          m_err;
  int          log_tid[$];
  logic [31:0] log_pc[$];
  logic [31:0] m_icnt[N];
  logic [31:0] m_scnt;
  bit          o_infl[N];
  logic [31:0] o_npc[N];
  bit          acc;
  bit          fnd;
  int          pick;
  int          cand;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < N; t++) begin
        m_infl[t] = 0; m_npc[t] = BOOT; m_acc_pc[t] = 0; m_icnt[t] = 0;
      end
      m_rr = 0; m_valid = 0; m_tid = 0; m_pc = 0; m_err = 0; m_scnt = 0;
    end else begin
      acc    = m_valid && if_ready;
      o_infl = m_infl;
      o_npc  = m_npc;
      if (m_valid && !if_ready) m_scnt++;
      if (acc) begin
        m_infl[m_tid]   = 1;
        m_acc_pc[m_tid] = m_pc;
        m_icnt[m_tid]++;
        m_rr = (m_tid + 1) % N;
        log_tid.push_back(m_tid);
        log_pc.push_back(m_pc);
      end
      for (int t = 0; t < N; t++) begin
        if (wb_done[t]) begin
          if (o_infl[t]) begin m_infl[t] = 0; m_npc[t] = wb_pc[t]; end
          else m_err = 1;
        end
      end
      if (!m_valid || if_ready) begin
        fnd = 0; pick = 0;
        for (int k = 0; k < N; k++) begin
          cand = (m_rr + k) % N;
          if (!fnd && !o_infl[cand] && thread_en[cand] &&
              !(m_valid && m_tid == cand) &&
              (!exc_en || int'(exc_thread) == cand)) begin
            fnd = 1; pick = cand;
          end
        end
        m_valid = fnd;
        if (fnd) begin m_tid = pick; m_pc = o_npc[pick]; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    logic [N-1:0] v;
    @(posedge clk);
    #2;
    for (int t = 0; t < N; t++) v[t] = m_infl[t];
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("if_thread", {30'b0, if_thread}, m_tid);
      chk("if_pc", if_pc, m_pc);
    end
    chk("inflight", {28'b0, inflight}, {28'b0, v});
    chk("proto_err", {31'b0, proto_err}, {31'b0, m_err});
`ifdef THREAD_SCHED_PERF_EN
    for (int t = 0; t < N; t++) chk("perf_issue_cnt", perf_issue_cnt[t], m_icnt[t]);
    chk("perf_stall_cnt", perf_stall_cnt, m_scnt);
`endif
  end

  // ---------------- stimulus ----------------
  int           mode = M_AUTO;
  logic [N-1:0] hold_mask = '0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mode != M_MANUAL) begin
        for (int t = 0; t < N; t++) begin
          wb_done[t] = 1'b0;
          if (m_infl[t] && !hold_mask[t]) begin
            if (mode == M_AUTO) begin
              wb_done[t] = 1'b1;
              wb_pc[t]   = m_acc_pc[t] + 32'd4;
            end else if ($urandom_range(0, 2) == 0) begin
              wb_done[t] = 1'b1;
              wb_pc[t]   = $urandom & 32'hFFFF_FFFC;
            end
          end else if (mode == M_RAND && $urandom_range(0, 299) == 0) begin
            wb_done[t] = 1'b1;
            wb_pc[t]   = $urandom;
          end
        end
      end
    end
  endtask

  task automatic enter_reset();
    rst = 1'b0; wb_done = '0; hold_mask = '0; exc_en = 1'b0;
    step(2);
  endtask

  function automatic int first_not(input int seg, input int v);
    for (int i = seg; i < log_tid.size(); i++) if (log_tid[i] != v) return log_tid[i];
    return -1;
  endfunction

  int seg, seg2, bad, cnt;

  initial begin
    wb_pc = '0; wb_done = '0; exc_en = 0; exc_thread = 0; thread_en = '1; if_ready = 0;
    step(3);
    chk("reset_if_valid", {31'b0, if_valid}, 32'd0);
    chk("reset_if_thread", {30'b0, if_thread}, 32'd0);
    chk("reset_if_pc", if_pc, 32'd0);
    chk("reset_inflight", {28'b0, inflight}, 32'd0);
    chk("reset_proto_err", {31'b0, proto_err}, 32'd0);

    // round robin with completion one cycle after each accept
    mode = M_AUTO; thread_en = 4'b1111; if_ready = 1; seg = log_tid.size();
    rst = 1'b1;
    step(8);
    chk("rr_count", (log_tid.size() - seg >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (log_tid.size() - seg >= 5) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_tid", log_tid[seg+i], i);
        chk("rr_pc", log_pc[seg+i], 32'h1000);
      end
      chk("rr_tid4", log_tid[seg+4], 0);
      chk("rr_pc4", log_pc[seg+4], 32'h1004);
    end

    // stalled request holds stable
    enter_reset();
    mode = M_MANUAL; thread_en = 4'b0010; if_ready = 1; rst = 1'b1;
    for (int i = 0; i < 20 && !m_infl[1]; i++) step(1);
    chk("hold_t1_issued", {31'b0, m_infl[1]}, 32'd1);
    wb_done[1] = 1'b1; wb_pc[1] = 32'h2000; if_ready = 0;
    step(1);
    wb_done = '0;
    for (int i = 0; i < 20 && !(m_valid && m_tid == 1 && m_pc == 32'h2000); i++) step(1);
    seg = log_tid.size();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, if_valid}, 32'd1);
      chk("hold_thread", {30'b0, if_thread}, 32'd1);
      chk("hold_pc", if_pc, 32'h2000);
      step(1);
    end
    chk("hold_no_accept", log_tid.size() - seg, 0);
    if_ready = 1;
    step(1);
    chk("hold_inflight1", {31'b0, inflight[1]}, 32'd1);
    step(3);
    chk("hold_one_accept", log_tid.size() - seg, 1);

    // exception master only
    enter_reset();
    mode = M_AUTO; thread_en = 4'b1111; exc_en = 1; exc_thread = 2'd2; if_ready = 1;
    seg = log_tid.size(); rst = 1'b1;
    step(16);
    chk("exc_only_t2", first_not(seg, 2), -1);
    chk("exc_progress", (log_tid.size() - seg >= 4) ? 32'd1 : 32'd0, 32'd1);
    exc_en = 0; seg2 = log_tid.size();
    step(10);
    chk("exc_resume_t3", first_not(seg2, 2), 3);

    // completion for a READY thread
    enter_reset();
    mode = M_MANUAL; thread_en = 4'b0000; if_ready = 1; rst = 1'b1;
    step(2);
    wb_done[0] = 1'b1; wb_pc[0] = 32'hDEAD_BEE0;
    step(1);
    wb_done = '0;
    chk("proto_set", {31'b0, proto_err}, 32'd1);
    mode = M_AUTO; thread_en = 4'b0001; seg = log_tid.size();
    step(5);
    chk("proto_pc_kept", (log_pc.size() > seg) ? log_pc[seg] : 32'hFFFF_FFFF, 32'h1000);
    step(10);
    chk("proto_sticky", {31'b0, proto_err}, 32'd1);

    // enable mask and disable while in flight
    enter_reset();
    mode = M_AUTO; thread_en = 4'b0101; if_ready = 1; seg = log_tid.size(); rst = 1'b1;
    step(12);
    bad = 0;
    for (int i = seg; i < log_tid.size(); i++) begin
      if (log_tid[i] != 0 && log_tid[i] != 2) bad++;
      if (i > seg && log_tid[i] == log_tid[i-1]) bad++;
    end
    chk("mask_alternate", bad, 0);
    chk("mask_progress", (log_tid.size() - seg >= 4) ? 32'd1 : 32'd0, 32'd1);
    hold_mask = 4'b0100;
    for (int i = 0; i < 20 && !m_infl[2]; i++) step(1);
    chk("mask_t2_inflight", {31'b0, inflight[2]}, 32'd1);
    thread_en = 4'b0001; seg2 = log_tid.size();
    step(3);
    hold_mask = '0;
    step(12);
    chk("mask_t2_done", {31'b0, inflight[2]}, 32'd0);
    cnt = 0;
    for (int i = seg2; i < log_tid.size(); i++) if (log_tid[i] == 2) cnt++;
    chk("mask_t2_not_reissued", cnt, 0);

    // reset mid-stream
    enter_reset();
    mode = M_AUTO; hold_mask = 4'b1000; thread_en = 4'b1000; if_ready = 1; rst = 1'b1;
    for (int i = 0; i < 20 && !m_infl[3]; i++) step(1);
    if_ready = 0; thread_en = 4'b1010;
    for (int i = 0; i < 20 && !(m_valid && m_tid == 1); i++) step(1);
    chk("mid_setup_t1", {31'b0, if_valid}, 32'd1);
    chk("mid_setup_t3", {31'b0, inflight[3]}, 32'd1);
    rst = 1'b0;
    step(1);
    chk("mid_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_inflight", {28'b0, inflight}, 32'd0);
    hold_mask = '0; thread_en = 4'b1111; if_ready = 1; seg = log_tid.size();
    rst = 1'b1;
    step(8);
    if (log_tid.size() - seg >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("mid_tid", log_tid[seg+i], i);
        chk("mid_pc", log_pc[seg+i], 32'h1000);
      end
    end else chk("mid_issue_count", log_tid.size() - seg, 4);

    // randomized traffic
    enter_reset();
    mode = M_RAND; thread_en = 4'b1111; if_ready = 1; rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) thread_en = 4'($urandom);
      if ($urandom_range(0, 79) == 0) exc_en = ~exc_en;
      if ($urandom_range(0, 29) == 0) exc_thread = 2'($urandom);
      step(1);
    end
    chk("rand_progress", (log_tid.size() > 200) ? 32'd1 : 32'd0, 32'd1);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
